// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN finishes trivial cases in a single cycle.
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic              sign_q;
    logic              sign_r;

    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_trial;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;

    logic              early;
    logic [XLEN-1:0]   early_res;

    // Magnitudes: the most-negative value maps to 2^(XLEN-1) unsigned.
    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV)  || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed && rs1_val[XLEN-1];
        b_neg    = b_signed && rs2_val[XLEN-1];
        a_mag    = a_neg ? -rs1_val : rs1_val;
        b_mag    = b_neg ? -rs2_val : rs2_val;
    end

    // acc = {hi, lo}: multiply keeps {partial, multiplier},
    // divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} +
                    (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_trial = div_shift[XLEN-1:0] - opnd;
        if (op_q[2]) begin
            if (div_ge)
                acc_next = {div_trial, acc[XLEN-2:0], 1'b1};
            else
                acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        prod      = sign_q ? -acc_next : acc_next;
        quo       = acc_next[XLEN-1:0];
        rem       = acc_next[2*XLEN-1:XLEN];
        final_res = '0;
        case (op_q)
            OP_MUL:    final_res = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  final_res = prod[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   final_res = sign_q ? -quo : quo;
            OP_REM,
            OP_REMU:   final_res = sign_r ? -rem : rem;
            default:   final_res = '0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic a_zero;
    logic b_zero;
    logic ovf;

    always_comb begin
        a_zero = (rs1_val == '0);
        b_zero = (rs2_val == '0);
        ovf    = op[2] && !op[0] && (&rs2_val) &&
                 (rs1_val == {1'b1, {(XLEN-1){1'b0}}});
        early  = op[2] ? (b_zero || ovf) : (a_zero || b_zero);
        early_res = '0;
        if (op[2]) begin
            if (b_zero)
                early_res = op[1] ? rs1_val : '1;
            else
                early_res = op[1] ? '0 : rs1_val;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= '0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        rd_out <= rd_in;
                        cnt    <= '0;
                        opnd   <= op[2] ? b_mag : a_mag;
                        acc    <= {{XLEN{1'b0}}, op[2] ? a_mag : b_mag};
                        // A zero divisor must yield an all-ones quotient.
                        sign_q <= (a_neg ^ b_neg) &&
                                  !(op[2] && rs2_val == '0);
                        sign_r <= a_neg;
                        if (early) begin
                            result <= early_res;
                            state  <= S_FINISH;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        result <= final_res;
                        state  <= S_FINISH;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);
    assign reg_write = done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int n_cmp;
    int n_err;

    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    muldiv_unit #(.XLEN(64), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .reg_write (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [2:0] o,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        logic signed [127:0] sp;
        logic [127:0] up;
        longint sa64;
        longint sb64;
        longint sr;
        sa   = {{64{a[63]}}, a};
        sb   = {{64{b[63]}}, b};
        sa64 = a;
        sb64 = b;
        case (o)
            3'd0: begin up = {64'b0, a} * {64'b0, b}; return up[63:0]; end
            3'd1: begin sp = sa * sb; return sp[127:64]; end
            3'd2: begin sp = sa * $signed({64'b0, b}); return sp[127:64]; end
            3'd3: begin up = {64'b0, a} * {64'b0, b}; return up[127:64]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == MIN && b == '1) return a;
                sr = sa64 / sb64;
                return sr;
            end
            3'd5: begin
                if (b == 0) return '1;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == '1) return 0;
                sr = sa64 % sb64;
                return sr;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (o[2]) begin
            if (b == 0) return 1;
            if (!o[0] && a == MIN && b == '1) return 1;
        end else if (a == 0 || b == 0) begin
            return 1;
        end
`endif
        return 65;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return MIN;
            3: return 64'($urandom_range(0, 300));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called #1 after an edge; lat counts edges from the start edge to done.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          output logic [63:0] res, output logic [4:0] rdo,
                          output int lat, output int wr_len,
                          output logic bsy);
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        lat     = -1;
        wr_len  = 0;
        bsy     = 1'b0;
        res     = '0;
        rdo     = '0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start   = 1'b0;
                bsy     = busy;
                rs1_val = {$urandom, $urandom};
                rs2_val = {$urandom, $urandom};
                rd_in   = 5'($urandom);
            end
            if (reg_write) wr_len++;
            if (done) begin
                lat = k;
                res = result;
                rdo = rd_out;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            if (reg_write) wr_len++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++;
        if ({busy, done, reg_write} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000",
                     {busy, done, reg_write});
        end
        n_cmp++;
        if (result !== 64'd0 || rd_out !== 5'd0) begin
            n_err++;
            $display("FAIL reset_regs: result=%h rd=%0d want 0/0",
                     result, rd_out);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10];
        logic [63:0] as  [10];
        logic [63:0] bs  [10];
        logic [63:0] exs [10];
        logic [63:0] res;
        logic [4:0]  rdo;
        int lat;
        int wr;
        logic bsy;
        ops[0] = 3'd0; as[0] = 64'd7;   bs[0] = -64'sd3; exs[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        ops[1] = 3'd3; as[1] = '1;      bs[1] = '1;      exs[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        ops[2] = 3'd1; as[2] = '1;      bs[2] = '1;      exs[2] = 64'd0;
        ops[3] = 3'd4; as[3] = -64'sd7; bs[3] = 64'd2;   exs[3] = 64'hFFFF_FFFF_FFFF_FFFD;
        ops[4] = 3'd6; as[4] = -64'sd7; bs[4] = 64'd2;   exs[4] = '1;
        ops[5] = 3'd7; as[5] = 64'd100; bs[5] = 64'd7;   exs[5] = 64'd2;
        ops[6] = 3'd5; as[6] = 64'd5;   bs[6] = 64'd0;   exs[6] = '1;
        ops[7] = 3'd7; as[7] = 64'd5;   bs[7] = 64'd0;   exs[7] = 64'd5;
        ops[8] = 3'd4; as[8] = MIN;     bs[8] = '1;      exs[8] = MIN;
        ops[9] = 3'd6; as[9] = MIN;     bs[9] = '1;      exs[9] = 64'd0;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 5), res, rdo, lat, wr, bsy);
            n_cmp++;
            if (res !== exs[i]) begin
                n_err++;
                $display("FAIL dir%0d_result: got %h want %h", i, res, exs[i]);
            end
            n_cmp++;
            if (lat != exp_lat(ops[i], as[i], bs[i])) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat,
                         exp_lat(ops[i], as[i], bs[i]));
            end
            n_cmp++;
            if (rdo !== 5'(i + 5) || wr != 1 || bsy !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_hs: rd=%0d wr_len=%0d busy=%b want %0d/1/1",
                         i, rdo, wr, bsy, i + 5);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [4:0]  rd;
        logic [4:0]  rdo;
        int lat;
        int wr;
        logic bsy;
        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            run_op(o, a, b, rd, res, rdo, lat, wr, bsy);
            n_cmp++;
            if (res !== ref_model(o, a, b) || rdo !== rd) begin
                n_err++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got %h rd=%0d want %h rd=%0d",
                         i, o, a, b, res, rdo, ref_model(o, a, b), rd);
            end
            n_cmp++;
            if (lat != exp_lat(o, a, b) || wr != 1) begin
                n_err++;
                $display("FAIL rand%0d_timing: lat=%0d wr_len=%0d want %0d/1",
                         i, lat, wr, exp_lat(o, a, b));
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [63:0] res;
        logic [4:0]  rdo;
        int wr;
        logic bsy;
        op = 3'd5; rs1_val = 64'd100; rs2_val = 64'd7; rd_in = 5'd9;
        start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 9) begin
                start = 1'b1; op = 3'd0;
                rs1_val = 64'd3; rs2_val = 64'd3; rd_in = 5'd3;
            end
            if (k == 10) start = 1'b0;
            if (done) begin
                lat = k; res = result; rdo = rd_out;
                break;
            end
        end
        n_cmp++;
        if (lat != 65 || res !== 64'd14 || rdo !== 5'd9) begin
            n_err++;
            $display("FAIL ignore_start: lat=%0d res=%0d rd=%0d want 65/14/9",
                     lat, res, rdo);
        end
        // First IDLE cycle after done: a fresh start must be accepted.
        @(posedge clk); #1;
        run_op(3'd0, 64'd3, 64'd3, 5'd4, res, rdo, lat, wr, bsy);
        n_cmp++;
        if (res !== 64'd9 || rdo !== 5'd4 || lat != 65 || bsy !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back: res=%0d rd=%0d lat=%0d busy=%b want 9/4/65/1",
                     res, rdo, lat, bsy);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        op = 3'd0; rs1_val = 64'd5; rs2_val = 64'd6; rd_in = 5'd17;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || result !== 64'd0 || rd_out !== 5'd0) begin
            n_err++;
            $display("FAIL reset_abort: busy=%b res=%h rd=%0d want 0/0/0",
                     busy, result, rd_out);
        end
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (done || reg_write) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d done cycles want 0", seen);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
